// File: rtl/dds_pkg.sv
// Shared types and constants for the multi-channel DDS: waveform modes,
// config-select codes, FSM state encoding and the channel-index width helper.
package dds_pkg;

  typedef enum logic [1:0] {
    MODE_SINE   = 2'd0,
    MODE_TRI    = 2'd1,
    MODE_SQUARE = 2'd2,
    MODE_SAW    = 2'd3
  } mode_e;

  localparam logic [1:0] CFG_FTW   = 2'd0;
  localparam logic [1:0] CFG_PHASE = 2'd1;
  localparam logic [1:0] CFG_MODE  = 2'd2;

  typedef logic [1:0] state_t;
  localparam state_t ST_IDLE = 2'd0;
  localparam state_t ST_ADDR = 2'd1;
  localparam state_t ST_READ = 2'd2;
  localparam state_t ST_OUT  = 2'd3;

  function automatic int ch_width(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/quarter_sine_rom.sv
// Registered-output quarter-wave sine magnitude table, 2^LUT_ADDR+1 entries,
// mag[k] = round((2^(SINE_SIZE-1)-1) * sin(pi/2 * k / 2^LUT_ADDR)).
module quarter_sine_rom #(
  parameter int SINE_SIZE = 12,
  parameter int LUT_ADDR  = 8
) (
  input  logic                 clock_i,
  input  logic [LUT_ADDR:0]    addr_i,
  output logic [SINE_SIZE-2:0] data_o
);

  localparam int DEPTH = 2 ** LUT_ADDR + 1;
  localparam int MAG_W = SINE_SIZE - 1;

  // Taylor series keeps the table a pure constant function of k.
  function automatic logic [MAG_W-1:0] mag_of(input int k);
    real x;
    real term;
    real sum;
    x    = 3.14159265358979323846 / 2.0 * real'(k) / real'(2 ** LUT_ADDR);
    term = x;
    sum  = x;
    for (int n = 1; n < 12; n++) begin
      term = -term * x * x / real'((2 * n) * (2 * n + 1));
      sum  = sum + term;
    end
    return MAG_W'(int'(real'(2 ** MAG_W - 1) * sum));
  endfunction

  logic [MAG_W-1:0] rom_tab [DEPTH];
  logic [MAG_W-1:0] data_q;

  for (genvar k = 0; k < DEPTH; k++) begin : g_tab
    assign rom_tab[k] = mag_of(k);
  end

  always_ff @(posedge clock_i) begin
    data_q <= rom_tab[addr_i];
  end

  assign data_o = data_q;

endmodule

// File: rtl/multi_channel_dds.sv
// Time-multiplexed DDS: one sweep of all channels per sample tick, sharing a
// single quarter-wave ROM, delivering samples over a valid/ready stream.
//
//   state   | meaning
//   --------+-----------------------------------------------------------
//   IDLE    | waiting for sample_tick; sync clears accumulators here
//   ADDR    | latch channel config, form phase P and ROM address
//   READ    | ROM data being registered
//   OUT     | sample valid; hold until out_ready, then advance accumulator
module multi_channel_dds
  import dds_pkg::*;
#(
  parameter int  NUM_CH     = 4,
  parameter int  SINE_SIZE  = 12,
  parameter int  ACC_SIZE   = 24,
  parameter int  LUT_ADDR   = 8,
  parameter int  PHASE_SIZE = 8,
  localparam int CH_W       = ch_width(NUM_CH)
) (
  input  logic                 clock_i,
  input  logic                 reset_n_i,
  input  logic                 sample_tick_i,
  input  logic                 sync_i,
  input  logic                 cfg_we_i,
  input  logic [CH_W-1:0]      cfg_ch_i,
  input  logic [1:0]           cfg_sel_i,
  input  logic [ACC_SIZE-1:0]  cfg_data_i,
  input  logic [NUM_CH-1:0]    enable_i,
  output logic                 out_valid_o,
  input  logic                 out_ready_i,
  output logic [SINE_SIZE-1:0] out_data_o,
  output logic [CH_W-1:0]      out_ch_o,
  output logic                 busy_o,
  output logic                 overrun_o
);

  localparam int                   TOP_W    = SINE_SIZE + 1;
  localparam int                   PH_SHIFT = ACC_SIZE - PHASE_SIZE;
  localparam logic [SINE_SIZE-1:0] MID      = SINE_SIZE'(1) << (SINE_SIZE - 1);
  localparam logic [LUT_ADDR:0]    QUARTER  = (LUT_ADDR + 1)'(2 ** LUT_ADDR);
  localparam logic [CH_W-1:0]      LAST_CH  = CH_W'(NUM_CH - 1);

  state_t                state_q, state_d;
  logic [CH_W-1:0]       ch_q, ch_d;
  logic [ACC_SIZE-1:0]   acc_q [NUM_CH];
  logic [ACC_SIZE-1:0]   acc_d [NUM_CH];
  logic [ACC_SIZE-1:0]   ftw_q [NUM_CH];
  logic [ACC_SIZE-1:0]   ftw_d [NUM_CH];
  logic [PHASE_SIZE-1:0] phase_q [NUM_CH];
  logic [PHASE_SIZE-1:0] phase_d [NUM_CH];
  mode_e                 mode_q [NUM_CH];
  mode_e                 mode_d [NUM_CH];
  logic                  overrun_q, overrun_d;
  logic                  sync_pend_q, sync_pend_d;
  mode_e                 mode_l_q, mode_l_d;
  logic [ACC_SIZE-1:0]   ftw_l_q, ftw_l_d;
  logic                  en_l_q, en_l_d;
  logic [TOP_W-1:0]      p_top_q, p_top_d;
  logic [LUT_ADDR:0]     rom_addr_q, rom_addr_d;

  logic [ACC_SIZE-1:0]   p_full;
  logic [LUT_ADDR-1:0]   lut_a;
  logic [LUT_ADDR:0]     rom_idx;
  logic                  unused_p;
  logic [SINE_SIZE-2:0]  mag;
  logic [SINE_SIZE-1:0]  sine_v, tri_v, sample;

  assign p_full   = acc_q[ch_q] + (ACC_SIZE'(phase_q[ch_q]) << PH_SHIFT);
  assign lut_a    = p_full[ACC_SIZE-3 -: LUT_ADDR];
  // Odd quadrants walk the quarter table backwards.
  assign rom_idx  = p_full[ACC_SIZE-2] ? QUARTER - {1'b0, lut_a} : {1'b0, lut_a};
  assign unused_p = ^p_full;

  always_comb begin
    state_d     = state_q;
    ch_d        = ch_q;
    acc_d       = acc_q;
    ftw_d       = ftw_q;
    phase_d     = phase_q;
    mode_d      = mode_q;
    overrun_d   = overrun_q;
    sync_pend_d = sync_pend_q;
    mode_l_d    = mode_l_q;
    ftw_l_d     = ftw_l_q;
    en_l_d      = en_l_q;
    p_top_d     = p_top_q;
    rom_addr_d  = rom_addr_q;

    if (cfg_we_i && (int'(cfg_ch_i) < NUM_CH)) begin
      case (cfg_sel_i)
        CFG_FTW:   ftw_d[cfg_ch_i]   = cfg_data_i;
        CFG_PHASE: phase_d[cfg_ch_i] = cfg_data_i[PHASE_SIZE-1:0];
        CFG_MODE:  mode_d[cfg_ch_i]  = mode_e'(cfg_data_i[1:0]);
        default: ;
      endcase
    end

    if (state_q != ST_IDLE) begin
      if (sample_tick_i) overrun_d = 1'b1;
      if (sync_i)        sync_pend_d = 1'b1;
    end

    case (state_q)
      ST_IDLE: begin
        if (sync_i) begin
          for (int i = 0; i < NUM_CH; i++) acc_d[i] = '0;
        end
        if (sample_tick_i) begin
          ch_d    = '0;
          state_d = ST_ADDR;
        end
      end
      ST_ADDR: begin
        mode_l_d   = mode_q[ch_q];
        ftw_l_d    = ftw_q[ch_q];
        en_l_d     = enable_i[ch_q];
        p_top_d    = p_full[ACC_SIZE-1 -: TOP_W];
        rom_addr_d = rom_idx;
        state_d    = ST_READ;
      end
      ST_READ: state_d = ST_OUT;
      ST_OUT: begin
        if (out_ready_i) begin
          if (en_l_q) acc_d[ch_q] = acc_q[ch_q] + ftw_l_q;
          if (ch_q == LAST_CH) begin
            state_d = ST_IDLE;
            // A sync seen during the sweep wins over the final update.
            if (sync_pend_d) begin
              for (int i = 0; i < NUM_CH; i++) acc_d[i] = '0;
              sync_pend_d = 1'b0;
            end
          end else begin
            ch_d    = ch_q + CH_W'(1);
            state_d = ST_ADDR;
          end
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clock_i or negedge reset_n_i) begin
    if (!reset_n_i) begin
      state_q     <= ST_IDLE;
      ch_q        <= '0;
      acc_q       <= '{default: '0};
      ftw_q       <= '{default: '0};
      phase_q     <= '{default: '0};
      mode_q      <= '{default: MODE_SINE};
      overrun_q   <= 1'b0;
      sync_pend_q <= 1'b0;
      mode_l_q    <= MODE_SINE;
      ftw_l_q     <= '0;
      en_l_q      <= 1'b0;
      p_top_q     <= '0;
      rom_addr_q  <= '0;
    end else begin
      state_q     <= state_d;
      ch_q        <= ch_d;
      acc_q       <= acc_d;
      ftw_q       <= ftw_d;
      phase_q     <= phase_d;
      mode_q      <= mode_d;
      overrun_q   <= overrun_d;
      sync_pend_q <= sync_pend_d;
      mode_l_q    <= mode_l_d;
      ftw_l_q     <= ftw_l_d;
      en_l_q      <= en_l_d;
      p_top_q     <= p_top_d;
      rom_addr_q  <= rom_addr_d;
    end
  end

  quarter_sine_rom #(
    .SINE_SIZE (SINE_SIZE),
    .LUT_ADDR  (LUT_ADDR)
  ) u_rom (
    .clock_i (clock_i),
    .addr_i  (rom_addr_q),
    .data_o  (mag)
  );

  assign sine_v = p_top_q[TOP_W-1] ? MID - {1'b0, mag} : MID + {1'b0, mag};
  assign tri_v  = p_top_q[TOP_W-1] ? ~p_top_q[SINE_SIZE-1:0] : p_top_q[SINE_SIZE-1:0];

  always_comb begin
    sample = MID;
    if (en_l_q) begin
      case (mode_l_q)
        MODE_SINE:   sample = sine_v;
        MODE_TRI:    sample = tri_v;
        MODE_SQUARE: sample = p_top_q[TOP_W-1] ? '0 : '1;
        MODE_SAW:    sample = p_top_q[TOP_W-1 -: SINE_SIZE];
        default:     sample = MID;
      endcase
    end
  end

  assign out_valid_o = (state_q == ST_OUT);
  assign out_data_o  = sample;
  assign out_ch_o    = ch_q;
  assign busy_o      = (state_q != ST_IDLE);
  assign overrun_o   = overrun_q;

endmodule
